// File: rtl/lbp_hist.sv
// lbp_hist: uniform-LBP histogram of an 8x8 frame, dumped bin by bin over a valid/ready handshake.
// Optional LBP_HIST_BORDER_CHK_EN drops writes that land on the outer pixel ring.
module lbp_hist #(
    parameter int CNT_W  = 7,
    parameter int DATA_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        lbp_addr,
    input  logic              lbp_write,
    input  logic [DATA_W-1:0] lbp_data,
    input  logic              finish,
    output logic [3:0]        hist_bin,
    output logic [CNT_W-1:0]  hist_cnt,
    output logic              hist_valid,
    input  logic              hist_ready,
    output logic              hist_done
);
    typedef enum logic [1:0] {ACC, DUMP, DONE} state_t;
    state_t           state;
    logic [CNT_W-1:0] cnt [10];
    logic [3:0]       idx;
    logic [7:0]       code;
    logic [7:0]       trans;
    logic [3:0]       pop_c;
    logic [3:0]       pop_t;
    logic [3:0]       bin;
    logic             hit;
    logic             unused;

    assign unused = ^{lbp_addr, lbp_data[DATA_W-1:8]};

    // trans marks every neighbouring bit pair that differs around the circle
    always_comb begin
        code  = lbp_data[7:0];
        trans = code ^ {code[0], code[7:1]};
        pop_c = '0;
        pop_t = '0;
        for (int i = 0; i < 8; i++) begin
            pop_c = pop_c + {3'd0, code[i]};
            pop_t = pop_t + {3'd0, trans[i]};
        end
        bin = (pop_t <= 4'd2) ? pop_c : 4'd9;
`ifdef LBP_HIST_BORDER_CHK_EN
        hit = lbp_write && !(lbp_addr[5:3] == 3'd0 || lbp_addr[5:3] == 3'd7 ||
                             lbp_addr[2:0] == 3'd0 || lbp_addr[2:0] == 3'd7);
`else
        hit = lbp_write;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ACC;
            idx   <= '0;
            for (int i = 0; i < 10; i++) cnt[i] <= '0;
        end else begin
            case (state)
                ACC: begin
                    if (hit && cnt[bin] != '1) cnt[bin] <= cnt[bin] + 1'b1;
                    if (finish) state <= DUMP;
                end
                DUMP: begin
                    if (hist_ready) begin
                        if (idx == 4'd9) begin
                            state <= DONE;
                            idx   <= '0;
                            for (int i = 0; i < 10; i++) cnt[i] <= '0;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                DONE:    state <= ACC;
                default: state <= ACC;
            endcase
        end
    end

    assign hist_bin   = idx;
    assign hist_cnt   = cnt[idx];
    assign hist_valid = (state == DUMP);
    assign hist_done  = (state == DONE);
endmodule
